// File: rtl/plab2_proc_muldiv_iter.sv
// Iterative multiply/divide unit: one bit of work per cycle, one operation in flight.
// Shift-add multiply and restoring divide share the operand and accumulator registers.
module plab2_proc_muldiv_iter #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2:0]         req_msg_fn,
  input  logic [p_nbits-1:0] req_msg_a,
  input  logic [p_nbits-1:0] req_msg_b,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [p_nbits-1:0] resp_msg
);

  localparam int c_cw = (p_nbits > 1) ? $clog2(p_nbits) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(p_nbits - 1);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [c_cw-1:0]    count;
  logic [2:0]         fn;
  logic [p_nbits-1:0] a_reg;
  logic [p_nbits-1:0] b_reg;
  logic [p_nbits-1:0] acc;
  logic               neg_q;
  logic               neg_r;
  logic [p_nbits-1:0] result;

  logic               req_signed;
  logic               a_neg;
  logic               b_neg;
  logic [p_nbits-1:0] a_in;
  logic [p_nbits-1:0] b_in;

  // Signed divide/remainder work on magnitudes; a zero divisor never negates the quotient
  always_comb begin
    req_signed = (req_msg_fn == FN_DIV) || (req_msg_fn == FN_REM);
    a_neg      = req_msg_a[p_nbits-1];
    b_neg      = req_msg_b[p_nbits-1];
    a_in       = req_msg_a;
    b_in       = req_msg_b;
    if (req_signed && a_neg) a_in = -req_msg_a;
    if (req_signed && b_neg) b_in = -req_msg_b;
  end

  logic [p_nbits:0]   rem_shift;
  logic [p_nbits:0]   diff;
  logic [p_nbits-1:0] acc_next;
  logic [p_nbits-1:0] a_next;
  logic [p_nbits-1:0] b_next;

  // Multiply: a_reg is the shifting multiplicand, b_reg the shifting multiplier.
  // Divide: a_reg shifts the dividend out and the quotient in, acc holds the remainder.
  always_comb begin
    rem_shift = {acc, a_reg[p_nbits-1]};
    diff      = rem_shift - {1'b0, b_reg};
    acc_next  = acc;
    a_next    = a_reg;
    b_next    = b_reg;
    if (fn == FN_MUL) begin
      acc_next = acc + (b_reg[0] ? a_reg : {p_nbits{1'b0}});
      a_next   = a_reg << 1;
      b_next   = b_reg >> 1;
    end else if (!diff[p_nbits]) begin
      acc_next = diff[p_nbits-1:0];
      a_next   = {a_reg[p_nbits-2:0], 1'b1};
    end else begin
      acc_next = rem_shift[p_nbits-1:0];
      a_next   = {a_reg[p_nbits-2:0], 1'b0};
    end
  end

  logic [p_nbits-1:0] fixed;

  always_comb begin
    fixed = '0;
    case (fn)
      FN_MUL:  fixed = acc_next;
      FN_DIV:  fixed = neg_q ? -a_next : a_next;
      FN_DIVU: fixed = a_next;
      FN_REM:  fixed = neg_r ? -acc_next : acc_next;
      FN_REMU: fixed = acc_next;
      default: fixed = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      fn       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result   <= '0;
      req_rdy  <= 1'b1;
      resp_val <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val && req_rdy) begin
            fn      <= req_msg_fn;
            a_reg   <= a_in;
            b_reg   <= b_in;
            acc     <= '0;
            neg_q   <= req_signed && (a_neg != b_neg) && (req_msg_b != '0);
            neg_r   <= req_signed && a_neg;
            count   <= c_last;
            state   <= CALC;
            req_rdy <= 1'b0;
          end
        end
        CALC: begin
          a_reg <= a_next;
          b_reg <= b_next;
          acc   <= acc_next;
          if (count == '0) begin
            result   <= fixed;
            state    <= DONE;
            resp_val <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          if (resp_val && resp_rdy) begin
            state    <= IDLE;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          req_rdy  <= 1'b1;
          resp_val <= 1'b0;
        end
      endcase
    end
  end

  assign resp_msg = result;

endmodule
